// File: rtl/sprite_overlay_engine.sv
// sprite_overlay_engine
//   Overlays N_REG runtime-positioned rectangular bitmaps on a VGA pixel
//   stream. All regions share one external synchronous ROM with a 1-cycle
//   read. The design adds colour-key transparency, fixed index priority
//   (lowest index wins), per-region enable and per-region blink.
//
//   Pipeline: S1 hit test + address, S2 ROM read, S3 output register.
//   A pixel presented in cycle t appears on rgb_out in cycle t+3.
//   The stream runs continuously at one pixel per clock. There is no
//   valid/ready handshake and no stall. video_on only qualifies the
//   pixel that travels with it.
//
// Ports
//   clk, reset          pixel clock; asynchronous active-low reset
//   pixel_x/y, video_on current pixel position and active-area flag
//   frame_tick          one pulse per frame; advances the blink counter
//   reg_en/reg_blink    per-region enable / blink mode
//   reg_x0/y0/w/h/base  packed per-region geometry and ROM base address
//   rom_addr/rom_data   shared ROM read port (data valid 1 cycle later)
//   rgb_out/hit_out     overlay colour; hit_out is set for an opaque region pixel
//   region_id           winning region index (0 when hit_out=0)
module sprite_overlay_engine #(
  parameter int              N_REG     = 4,
  parameter int              PIX_W     = 12,
  parameter int              COORD_W   = 10,
  parameter int              ADDR_W    = 13,
  parameter logic [PIX_W-1:0] TRANSP   = 12'hF0F,
  parameter logic [PIX_W-1:0] BG       = 12'h000,
  parameter int              BLINK_LOG = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [COORD_W-1:0]         pixel_x,
  input  logic [COORD_W-1:0]         pixel_y,
  input  logic                       video_on,
  input  logic                       frame_tick,
  input  logic [N_REG-1:0]           reg_en,
  input  logic [N_REG-1:0]           reg_blink,
  input  logic [N_REG*COORD_W-1:0]   reg_x0,
  input  logic [N_REG*COORD_W-1:0]   reg_y0,
  input  logic [N_REG*COORD_W-1:0]   reg_w,
  input  logic [N_REG*COORD_W-1:0]   reg_h,
  input  logic [N_REG*ADDR_W-1:0]    reg_base,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [PIX_W-1:0]           rom_data,
  output logic [PIX_W-1:0]           rgb_out,
  output logic                       hit_out,
  output logic [2:0]                 region_id
);

  localparam int CW2 = 2 * COORD_W;

  logic [BLINK_LOG-1:0] blink_cnt_q, blink_cnt_d;
  logic [ADDR_W-1:0]    rom_addr_q, rom_addr_d;
  logic                 hit1_q, hit1_d, hit2_q;
  logic [2:0]           id1_q, id1_d, id2_q;
  logic [PIX_W-1:0]     rgb_q, rgb_d;
  logic                 hit_q, hit_d;
  logic [2:0]           rid_q, rid_d;

  logic [COORD_W-1:0]   x0_a [N_REG];
  logic [COORD_W-1:0]   y0_a [N_REG];
  logic [COORD_W-1:0]   w_a  [N_REG];
  logic [COORD_W-1:0]   h_a  [N_REG];
  logic [ADDR_W-1:0]    base_a [N_REG];
  logic [N_REG-1:0]     hit_v;

  // Blink-hidden phase is the upper half of the counter period.
  logic blink_off;
  assign blink_off = blink_cnt_q[BLINK_LOG-1];

  for (genvar g = 0; g < N_REG; g++) begin : g_reg
    logic in_x, in_y;
    assign x0_a[g]   = reg_x0[g*COORD_W +: COORD_W];
    assign y0_a[g]   = reg_y0[g*COORD_W +: COORD_W];
    assign w_a[g]    = reg_w[g*COORD_W +: COORD_W];
    assign h_a[g]    = reg_h[g*COORD_W +: COORD_W];
    assign base_a[g] = reg_base[g*ADDR_W +: ADDR_W];
    // One extra bit keeps x0+w from wrapping back to column 0.
    assign in_x = ({1'b0, pixel_x} >= {1'b0, x0_a[g]}) &&
                  ({1'b0, pixel_x} <  ({1'b0, x0_a[g]} + {1'b0, w_a[g]}));
    assign in_y = ({1'b0, pixel_y} >= {1'b0, y0_a[g]}) &&
                  ({1'b0, pixel_y} <  ({1'b0, y0_a[g]} + {1'b0, h_a[g]}));
    assign hit_v[g] = reg_en[g] && !(reg_blink[g] && blink_off) && in_x && in_y;
  end

  // Priority select: scan from the top so the lowest hitting index is the
  // last assignment and therefore wins.
  logic               any_hit;
  logic [2:0]         win_id;
  logic [COORD_W-1:0] sel_x0, sel_y0, sel_w;
  logic [ADDR_W-1:0]  sel_base;
  logic [COORD_W-1:0] dx, dy;

  always_comb begin
    any_hit  = |hit_v;
    win_id   = '0;
    sel_x0   = '0;
    sel_y0   = '0;
    sel_w    = '0;
    sel_base = '0;
    for (int i = N_REG - 1; i >= 0; i--) begin
      if (hit_v[i]) begin
        win_id   = 3'(i);
        sel_x0   = x0_a[i];
        sel_y0   = y0_a[i];
        sel_w    = w_a[i];
        sel_base = base_a[i];
      end
    end
    dx = pixel_x - sel_x0;
    dy = pixel_y - sel_y0;
  end

  always_comb begin
    blink_cnt_d = frame_tick ? blink_cnt_q + BLINK_LOG'(1) : blink_cnt_q;
    // Row-major offset at 2*COORD_W bits, then truncated to the ROM width.
    // Without a hit the address is held so the ROM sees no needless toggling.
    rom_addr_d  = any_hit ? ADDR_W'(CW2'(dy) * CW2'(sel_w) + CW2'(dx) + CW2'(sel_base))
                          : rom_addr_q;
    hit1_d      = any_hit && video_on;
    id1_d       = win_id;
    // Colour-keyed pixels fall through to background rather than to a lower
    // priority region; hidden regions are never fetched.
    if (hit2_q && (rom_data != TRANSP)) begin
      rgb_d = rom_data;
      hit_d = 1'b1;
      rid_d = id2_q;
    end else begin
      rgb_d = BG;
      hit_d = 1'b0;
      rid_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt_q <= '0;
      rom_addr_q  <= '0;
      hit1_q      <= 1'b0;
      id1_q       <= '0;
      hit2_q      <= 1'b0;
      id2_q       <= '0;
      rgb_q       <= BG;
      hit_q       <= 1'b0;
      rid_q       <= '0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      rom_addr_q  <= rom_addr_d;
      hit1_q      <= hit1_d;
      id1_q       <= id1_d;
      hit2_q      <= hit1_q;
      id2_q       <= id1_q;
      rgb_q       <= rgb_d;
      hit_q       <= hit_d;
      rid_q       <= rid_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign rgb_out   = rgb_q;
  assign hit_out   = hit_q;
  assign region_id = rid_q;

endmodule

// File: tb/tb_sprite_overlay_engine.sv
module tb_sprite_overlay_engine;

  localparam int N_REG = 4;
  localparam int CW    = 10;
  localparam int AW    = 13;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [CW-1:0]   pixel_x = '0, pixel_y = '0;
  logic            video_on = 1'b0, frame_tick = 1'b0;
  logic [N_REG-1:0] reg_en = '0, reg_blink = '0;
  logic [N_REG*CW-1:0] reg_x0 = '0, reg_y0 = '0, reg_w = '0, reg_h = '0;
  logic [N_REG*AW-1:0] reg_base = '0;
  logic [AW-1:0]   rom_addr;
  logic [11:0]     rom_data = '0;
  logic [11:0]     rgb_out;
  logic            hit_out;
  logic [2:0]      region_id;

  sprite_overlay_engine #(.N_REG(N_REG), .BLINK_LOG(2)) dut (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .frame_tick(frame_tick), .reg_en(reg_en),
    .reg_blink(reg_blink), .reg_x0(reg_x0), .reg_y0(reg_y0), .reg_w(reg_w),
    .reg_h(reg_h), .reg_base(reg_base), .rom_addr(rom_addr),
    .rom_data(rom_data), .rgb_out(rgb_out), .hit_out(hit_out),
    .region_id(region_id)
  );

  // clock / ROM model
  always #5 clk = ~clk;

  logic [11:0] rom [0:8191];
  always @(posedge clk) rom_data <= rom[rom_addr];

  // scoreboard
  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pix_word();
    return {hit_out, region_id, rgb_out};
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic set_pix(input int px, input int py, input logic vid);
    pixel_x  = 10'(px);
    pixel_y  = 10'(py);
    video_on = vid;
  endtask

  task automatic set_region(input int i, input int x0, input int y0,
                            input int w, input int h, input int base);
    reg_x0[i*CW +: CW]   = 10'(x0);
    reg_y0[i*CW +: CW]   = 10'(y0);
    reg_w[i*CW +: CW]    = 10'(w);
    reg_h[i*CW +: CW]    = 10'(h);
    reg_base[i*AW +: AW] = 13'(base);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rgb"},  {4'h0, rgb_out}, 16'h0000);
    check({tag, "_hit"},  {15'h0, hit_out}, 16'h0000);
    check({tag, "_id"},   {13'h0, region_id}, 16'h0000);
    check({tag, "_addr"}, {3'h0, rom_addr}, 16'h0000);
  endtask

  // Reference model: independent of the pipeline, returns {hit,id,rgb}.
  function automatic logic [15:0] model(input int px, input int py, input logic vid);
    int   win = -1;
    int   a;
    logic [11:0] d;
    for (int i = N_REG - 1; i >= 0; i--) begin
      int x0 = int'(reg_x0[i*CW +: CW]);
      int y0 = int'(reg_y0[i*CW +: CW]);
      int w  = int'(reg_w[i*CW +: CW]);
      int h  = int'(reg_h[i*CW +: CW]);
      if (reg_en[i] && px >= x0 && px < x0 + w && py >= y0 && py < y0 + h) win = i;
    end
    if (win < 0 || !vid) return 16'h0000;
    a = int'(reg_base[win*AW +: AW]) +
        (py - int'(reg_y0[win*CW +: CW])) * int'(reg_w[win*CW +: CW]) +
        (px - int'(reg_x0[win*CW +: CW]));
    d = rom[a & 8191];
    if (d == 12'hF0F) return 16'h0000;
    return {1'b1, 3'(win), d};
  endfunction

  typedef struct {
    logic [3:0]  en;
    int          px;
    int          py;
    logic        vid;
    logic        chk_addr;
    logic [12:0] addr;
    logic        hit;
    logic [2:0]  id;
    logic [11:0] rgb;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [3:0] en, input int px, input int py,
                              input logic vid, input logic ca, input int addr,
                              input logic hit, input int id, input logic [11:0] rgb);
    vec_t v;
    v.en = en; v.px = px; v.py = py; v.vid = vid; v.chk_addr = ca;
    v.addr = 13'(addr); v.hit = hit; v.id = 3'(id); v.rgb = rgb;
    return v;
  endfunction

  initial begin
    // ROM image: word = 0x400 | addr[9:0]; one colour-keyed word at 1726.
    for (int a = 0; a < 8192; a++) rom[a] = 12'h400 | 12'(a & 1023);
    rom[1726] = 12'hF0F;

    set_region(0, 15, 72, 60, 38, 0);
    set_region(1, 50, 90, 60, 15, 3000);
    set_region(2, 300, 200, 20, 10, 5000);
    set_region(3, 1023, 0, 5, 10, 6000);

    tbl.push_back(mk(4'hF, 15, 72, 1, 1, 0, 1, 0, 12'h400));
    tbl.push_back(mk(4'hF, 74, 109, 1, 1, 2279, 1, 0, 12'h4E7));
    tbl.push_back(mk(4'hF, 75, 109, 1, 1, 2279, 0, 0, 12'h000));
    tbl.push_back(mk(4'hF, 60, 100, 1, 1, 1725, 1, 0, 12'h6BD));
    tbl.push_back(mk(4'hE, 60, 100, 1, 1, 3610, 1, 1, 12'h61A));
    tbl.push_back(mk(4'hF, 100, 100, 1, 1, 3650, 1, 1, 12'h642));
    tbl.push_back(mk(4'hF, 61, 100, 1, 1, 1726, 0, 0, 12'h000));
    tbl.push_back(mk(4'hE, 61, 100, 1, 1, 3611, 1, 1, 12'h61B));
    tbl.push_back(mk(4'hF, 1023, 5, 1, 1, 6025, 1, 3, 12'h789));
    tbl.push_back(mk(4'hF, 0, 5, 1, 1, 6025, 0, 0, 12'h000));
    tbl.push_back(mk(4'hF, 3, 5, 1, 1, 6025, 0, 0, 12'h000));
    tbl.push_back(mk(4'hF, 15, 72, 0, 0, 0, 0, 0, 12'h000));
    tbl.push_back(mk(4'hF, 305, 203, 1, 1, 5065, 1, 2, 12'h7C9));
    tbl.push_back(mk(4'hB, 305, 203, 1, 1, 5065, 0, 0, 12'h000));

    // reset block
    reg_en = 4'hF;
    steps(3);
    check_reset_vals("reset");
    reset = 1'b1;

    // table-driven steady-state vectors
    foreach (tbl[k]) begin
      reg_en = tbl[k].en;
      set_pix(tbl[k].px, tbl[k].py, tbl[k].vid);
      steps(4);
      check($sformatf("vec%0d_pix", k), pix_word(), {tbl[k].hit, tbl[k].id, tbl[k].rgb});
      if (tbl[k].chk_addr)
        check($sformatf("vec%0d_addr", k), {3'h0, rom_addr}, {3'h0, tbl[k].addr});
    end

    // latency: one pixel in, addr at t+1, colour at t+3 only
    reg_en = 4'hF;
    set_pix(74, 109, 1); steps(4);
    set_pix(500, 500, 0); steps(4);
    check("lat_idle_addr", {3'h0, rom_addr}, 16'd2279);
    set_pix(15, 72, 1); step();
    check("lat_t1_addr", {3'h0, rom_addr}, 16'd0);
    check("lat_t1_pix", pix_word(), 16'h0000);
    set_pix(500, 500, 0); step();
    check("lat_t2_pix", pix_word(), 16'h0000);
    step();
    check("lat_t3_pix", pix_word(), 16'h8400);
    step();
    check("lat_t4_pix", pix_word(), 16'h0000);

    // zero width / zero height never hit
    set_region(2, 300, 200, 0, 10, 5000);
    set_pix(300, 200, 1); steps(4);
    check("w0_pix", pix_word(), 16'h0000);
    set_region(2, 300, 200, 20, 0, 5000);
    steps(4);
    check("h0_pix", pix_word(), 16'h0000);
    set_region(2, 300, 200, 20, 10, 5000);

    // blink on region 2 with a 4-frame period
    reg_blink = 4'b0100;
    set_pix(305, 203, 1); steps(4);
    check("blink_f0", pix_word(), 16'hA7C9);
    for (int f = 1; f <= 4; f++) begin
      frame_tick = 1'b1; step(); frame_tick = 1'b0; steps(4);
      check($sformatf("blink_f%0d", f), pix_word(), (f == 2 || f == 3) ? 16'h0000 : 16'hA7C9);
    end
    frame_tick = 1'b1; step(); frame_tick = 1'b0; steps(4);
    check("blink_f5", pix_word(), 16'hA7C9);
    // tick coincident with a pixel: that pixel sees the pre-increment count
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    steps(2);
    check("tick_same_pix", pix_word(), 16'hA7C9);
    step();
    check("tick_next_pix", pix_word(), 16'h0000);
    reg_blink = 4'b0000;

    // asynchronous reset mid-stream
    set_pix(74, 109, 1); steps(4);
    check("pre_rst_pix", pix_word(), 16'h84E7);
    #2 reset = 1'b0;
    #1 check_reset_vals("async_rst");
    steps(2);
    reset = 1'b1;

    // random stream against the reference model after release
    for (int k = 0; k < 40; k++) begin
      int px, py;
      logic vid;
      logic [15:0] e;
      px  = $urandom_range(140, 0);
      py  = $urandom_range(140, 60);
      vid = 1'($urandom_range(1, 0));
      set_pix(px, py, vid);
      exp_q.push_back(model(px, py, vid));
      step();
      if (exp_q.size() == 3) begin
        e = exp_q.pop_front();
        check($sformatf("rand%0d", k), pix_word(), e);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
